svc_rv_div_seq: RTL and testbench
=================================

# svc_rv_div_seq

Sequencer for the RISC-V M-extension divide/remainder instructions. It contains a radix-2 restoring divider and the control that drives it. It accepts one operation at a time from EX, holds the pipeline stalled while it iterates, applies the signed/special-case rules, and presents the final result so it completes in MEM as the division result. Special cases bypass iteration and complete on a short path.

## Interface
Parameters:
- XLEN, 32, operand and result width; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a divide; sampled only in IDLE.
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data  input  XLEN  dividend.
- rs2_data  input  XLEN  divisor.
- flush  input  1  cancel any in-flight operation.
- stall  output  1  hold EX/MEM; combinational.
- busy  output  1  registered; high while iterating.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - With start=1 and flush=0: latch op, operand signs, absolute values (signed ops only), and a special-case flag.
  - If the op is special, go to DONE. Otherwise go to CALC with counter = XLEN.
- **CALC**
  - Each cycle: shift {rem, quo} left 1, trial-subtract the divisor magnitude, and keep the difference if it is non-negative, setting quo[0].
  - Decrement the counter. When the counter reaches 1, the next state is DONE.
- **DONE**
  - Register the final result, assert done for exactly this cycle, then return to IDLE.
- **Sign fix-up (signed ops)**
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Magnitudes are computed modulo 2^XLEN, so |MIN| = MIN unsigned, which is correct.
- **Special cases** (decided in IDLE, no iteration):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1_data.
  - DIV with rs1 = MIN and rs2 = −1: result MIN.
  - REM with rs1 = MIN and rs2 = −1: result 0.
- **Outputs**
  - stall = (state==IDLE && start && !flush) || state==CALC.
  - stall is low in DONE so the instruction advances with its result.
- **Boundary conditions**
  - start in CALC or DONE is ignored; no queueing.
  - flush in any state forces IDLE next cycle and suppresses done. result is left unchanged.
  - flush and start in the same IDLE cycle: flush wins, nothing is accepted.
  - Back-to-back: start is legal in the IDLE cycle that follows DONE.
  - Reset mid-operation: abandon it and return to IDLE.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - busy 0, done 0, result 0.
  - stall 0 unless start is asserted.
- Normal op, with start accepted at edge 0:
  - busy is high for cycles 1..XLEN.
  - done is high in cycle XLEN+1, giving latency XLEN+1 cycles (33 at XLEN=32).
  - stall is high in cycles 0..XLEN.
- Special case, with start accepted at edge 0:
  - done is high in cycle 1 and busy never rises.
  - stall is high in cycle 0 only.
- result is valid from the done cycle until the next accepted start.

## Test plan
- DIV rs1=−7 (0xFFFFFFF9), rs2=2 → result 0xFFFFFFFD (−3); done exactly 33 cycles after start; stall high for 33 cycles.
- REM −7,2 → 0xFFFFFFFF (−1). REMU 0xFFFFFFF9,2 → 1. DIVU 100,7 → 14.
- Divide by zero:
  - DIVU 0xFFFFFFFF,0 → 0xFFFFFFFF with done at cycle 1.
  - REM 5,0 → 5 with done at cycle 1.
- Overflow, each with done at cycle 1 and busy never high:
  - DIV 0x80000000,0xFFFFFFFF → 0x80000000.
  - REM 0x80000000,0xFFFFFFFF → 0.
- flush in cycle 10 of CALC:
  - Requires IDLE next cycle, no done pulse, and stall low.
  - A following DIV 9,3 → 3 with normal latency.
- start pulses with different operands during CALC and at DONE are ignored, and the original result is unchanged.
  - flush+start together in IDLE → nothing accepted.
  - Reset mid-CALC → busy 0 and done 0 the next cycle.

Source files
------------

// File: rtl/svc_rv_div_seq.sv
// RISC-V M-extension divide/remainder sequencer: radix-2 restoring divider
// with signed fix-up and short-path special cases (divide by zero, overflow).
module svc_rv_div_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            is_rem_q, is_rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;

   logic            is_signed, a_neg, b_neg, div_zero, ovf, accept;
   logic [XLEN-1:0] min_val, a_mag, b_mag, spec_res;
   logic [XLEN:0]   rem_sh;
   logic            fits;
   logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

   // Operand decode for the accept cycle; magnitudes wrap so |MIN| stays MIN.
   always_comb begin
      min_val   = {1'b1, {(XLEN-1){1'b0}}};
      is_signed = ~op[0];
      a_neg     = is_signed & rs1_data[XLEN-1];
      b_neg     = is_signed & rs2_data[XLEN-1];
      a_mag     = a_neg ? (~rs1_data + 1'b1) : rs1_data;
      b_mag     = b_neg ? (~rs2_data + 1'b1) : rs2_data;
      div_zero  = (rs2_data == '0);
      ovf       = is_signed & (rs1_data == min_val) & (rs2_data == '1);
      if (div_zero) begin
         spec_res = op[1] ? rs1_data : '1;
      end else begin
         spec_res = op[1] ? '0 : min_val;
      end
      accept    = start & ~flush;
   end

   // One restoring step; the last step's outputs feed the sign fix-up directly.
   always_comb begin
      rem_sh = {rem_q, quo_q[XLEN-1]};
      fits   = (rem_sh >= {1'b0, dvs_q});
      rem_nx = fits ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], fits};
      q_fix  = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
      r_fix  = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               is_rem_d  = op[1];
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dvs_d     = b_mag;
               rem_d     = '0;
               quo_d     = a_mag;
               if (div_zero || ovf) begin
                  state_d  = DONE;
                  result_d = spec_res;
               end else begin
                  state_d = CALC;
                  cnt_d   = CW'(XLEN);
               end
            end
         end
         CALC: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               result_d = is_rem_q ? r_fix : q_fix;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush abandons the operation without touching the visible result.
      if (flush) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
   assign busy   = (state_q == CALC);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_svc_rv_div_seq.sv
// Directed bench for svc_rv_div_seq: results, latency, stall/busy shape,
// special cases, flush, ignored starts and mid-operation reset.
module tb_svc_rv_div_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int total;
   int bad;

   svc_rv_div_seq #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .flush    (flush),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one op at a negedge and follows it to done; n counts cycles after start.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int n;
      int bc;
      int sc;
      @(negedge clk);
      chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      start = 1'b1; op = o; rs1_data = a; rs2_data = b;
      #1;
      chk({tag, "_stall0"}, {31'd0, stall}, 32'd1);
      sc = stall ? 1 : 0;
      bc = 0;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 100) begin
         if (busy)  bc++;
         if (stall) sc++;
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_result"}, result, exp);
      chk({tag, "_busy_cycles"}, bc, exp_lat - 1);
      chk({tag, "_stall_cycles"}, sc, exp_lat);
      chk({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dc;
      int bc;
      total = 0; bad = 0;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
      rs1_data = '0; rs2_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",   {31'd0, busy},  32'd0);
      chk("rst_done",   {31'd0, done},  32'd0);
      chk("rst_stall",  {31'd0, stall}, 32'd0);
      chk("rst_result", result,         32'd0);
      rst_n = 1'b1;

      do_op("div_m7_2",    2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      do_op("rem_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      do_op("remu_f9_2",   2'b11, 32'hFFFFFFF9, 32'd2,        32'd1,        33);
      do_op("divu_100_7",  2'b01, 32'd100,      32'd7,        32'd14,       33);
      do_op("div_7_m2",    2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      do_op("rem_7_m2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
      do_op("div_min_2",   2'b00, 32'h80000000, 32'd2,        32'hC0000000, 33);
      do_op("divu_fe_ff",  2'b01, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        33);
      do_op("divu_by0",    2'b01, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1);
      do_op("rem_by0",     2'b10, 32'd5,        32'd0,        32'd5,        1);
      do_op("div_ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      do_op("rem_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
      do_op("remu_fe_ff",  2'b11, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);

      // Flush in cycle 10 of CALC.
      @(negedge clk);
      start = 1'b1; op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("flush_busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy",   {31'd0, busy},  32'd0);
      chk("flush_stall",  {31'd0, stall}, 32'd0);
      chk("flush_done",   {31'd0, done},  32'd0);
      dc = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dc++;
      end
      chk("flush_no_done", dc, 0);
      chk("flush_result_kept", result, 32'hFFFFFFFE);
      do_op("div_9_3", 2'b00, 32'd9, 32'd3, 32'd3, 33);

      // Starts during CALC and at DONE are ignored.
      @(negedge clk);
      start = 1'b1; op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      repeat (4) begin
         @(negedge clk);
         n++;
      end
      start = 1'b1; op = 2'b00; rs1_data = 32'd1000; rs2_data = 32'd3;
      @(negedge clk);
      start = 1'b0;
      n++;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ign_latency", n, 33);
      chk("ign_result", result, 32'd14);
      start = 1'b1; op = 2'b10; rs1_data = 32'd55; rs2_data = 32'd4;
      @(negedge clk);
      start = 1'b0;
      chk("ign_done_start_busy", {31'd0, busy}, 32'd0);
      dc = 0; bc = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dc++;
         if (busy) bc++;
      end
      chk("ign_no_done", dc, 0);
      chk("ign_no_busy", bc, 0);
      chk("ign_result_kept", result, 32'd14);

      // flush and start together in IDLE.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b01; rs1_data = 32'd50; rs2_data = 32'd5;
      #1;
      chk("fs_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      dc = 0; bc = 0;
      repeat (40) begin
         if (done) dc++;
         if (busy) bc++;
         @(negedge clk);
      end
      chk("fs_no_done", dc, 0);
      chk("fs_no_busy", bc, 0);
      chk("fs_result_kept", result, 32'd14);

      // Reset mid-CALC.
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs1_data = 32'd77; rs2_data = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy",   {31'd0, busy}, 32'd0);
      chk("midrst_done",   {31'd0, done}, 32'd0);
      chk("midrst_result", result,        32'd0);
      rst_n = 1'b1;
      do_op("after_rst_divu", 2'b01, 32'd100, 32'd7, 32'd14, 33);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
